// File: rtl/byte_channel_bridge_if.sv
// Bundle of all requester-side and memory-side signals of byte_channel_bridge.
//   ask_*/ready_*  : CPU flow control (interrupt / restart handshake)
//   io_*           : data load/store requester
//   fe_*           : FETCH_CH instruction-fetch requesters, flattened per channel
//   m_*            : byte-serial memory/peripheral channel
// Modport slave is the bridge view; modport master is the surrounding system view.
interface byte_channel_bridge_if #(
  parameter int unsigned ADDR_W      = 40,
  parameter int unsigned FETCH_CH    = 2,
  parameter int unsigned INSTR_BYTES = 4
);
  logic                               ask_inter;
  logic                               ask_restart;
  logic                               ready_inter;
  logic                               ready_restart;

  logic                               io_valid;
  logic [ADDR_W-1:0]                  io_addr;
  logic                               io_rw;
  logic [1:0]                         io_width;
  logic [63:0]                        io_wdata;
  logic [63:0]                        io_rdata;
  logic                               io_ready;
  logic                               io_error;

  logic [FETCH_CH-1:0]                fe_valid;
  logic [FETCH_CH*ADDR_W-1:0]         fe_addr;
  logic [FETCH_CH*8*INSTR_BYTES-1:0]  fe_rdata;
  logic [FETCH_CH-1:0]                fe_ready;
  logic [FETCH_CH-1:0]                fe_error;

  logic                               m_valid;
  logic [ADDR_W-1:0]                  m_addr;
  logic                               m_rw;
  logic [7:0]                         m_wdata;
  logic [7:0]                         m_rdata;
  logic                               m_ready;
  logic                               m_error;

  modport slave (
    input  ask_inter, ask_restart,
    output ready_inter, ready_restart,
    input  io_valid, io_addr, io_rw, io_width, io_wdata,
    output io_rdata, io_ready, io_error,
    input  fe_valid, fe_addr,
    output fe_rdata, fe_ready, fe_error,
    output m_valid, m_addr, m_rw, m_wdata,
    input  m_rdata, m_ready, m_error
  );

  modport master (
    output ask_inter, ask_restart,
    input  ready_inter, ready_restart,
    output io_valid, io_addr, io_rw, io_width, io_wdata,
    input  io_rdata, io_ready, io_error,
    output fe_valid, fe_addr,
    input  fe_rdata, fe_ready, fe_error,
    input  m_valid, m_addr, m_rw, m_wdata,
    output m_rdata, m_ready, m_error
  );
endinterface

// File: rtl/byte_channel_bridge.sv
// Serialises one data-IO requester and FETCH_CH instruction-fetch requesters
// onto a single byte-wide memory channel (big-endian byte order, IO has priority,
// fetch channels round-robin). Writes in flight are drained before an interrupt.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : byte_channel_bridge_if.slave (ask/ready, io_*, fe_*, m_* groups)
module byte_channel_bridge #(
  parameter int unsigned ADDR_W      = 40,
  parameter int unsigned FETCH_CH    = 2,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  byte_channel_bridge_if.slave  bus
);

  localparam int unsigned FW = 8 * INSTR_BYTES;
  localparam int unsigned GW = (FETCH_CH > 1) ? $clog2(FETCH_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                        state_q, state_d;
  logic [GW-1:0]                 grant_q, grant_d;
  logic [GW-1:0]                 rr_q, rr_d;
  logic                          is_io_q, is_io_d;
  logic                          rw_q, rw_d;
  logic [3:0]                    nbytes_q, nbytes_d;
  logic [2:0]                    step_q, step_d;
  logic [63:0]                   wdata_q, wdata_d;
  logic                          m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]             m_addr_q, m_addr_d;
  logic [63:0]                   io_rdata_q, io_rdata_d;
  logic [FETCH_CH-1:0][FW-1:0]   fe_rdata_q, fe_rdata_d;
  logic                          io_ready_q, io_ready_d;
  logic                          io_error_q, io_error_d;
  logic [FETCH_CH-1:0]           fe_ready_q, fe_ready_d;
  logic [FETCH_CH-1:0]           fe_error_q, fe_error_d;
  logic                          ready_inter_q, ready_inter_d;

  logic                          abort;
  logic                          found;
  logic                          last;
  logic [GW-1:0]                 gsel;
  logic [GW-1:0]                 cand;
  logic [ADDR_W-1:0]             fe_addr_sel;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      is_io_q       <= 1'b0;
      rw_q          <= 1'b0;
      nbytes_q      <= '0;
      step_q        <= '0;
      wdata_q       <= '0;
      m_valid_q     <= 1'b0;
      m_addr_q      <= '0;
      io_rdata_q    <= '0;
      fe_rdata_q    <= '0;
      io_ready_q    <= 1'b0;
      io_error_q    <= 1'b0;
      fe_ready_q    <= '0;
      fe_error_q    <= '0;
      ready_inter_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      is_io_q       <= is_io_d;
      rw_q          <= rw_d;
      nbytes_q      <= nbytes_d;
      step_q        <= step_d;
      wdata_q       <= wdata_d;
      m_valid_q     <= m_valid_d;
      m_addr_q      <= m_addr_d;
      io_rdata_q    <= io_rdata_d;
      fe_rdata_q    <= fe_rdata_d;
      io_ready_q    <= io_ready_d;
      io_error_q    <= io_error_d;
      fe_ready_q    <= fe_ready_d;
      fe_error_q    <= fe_error_d;
      ready_inter_q <= ready_inter_d;
    end
  end

  // Next-state, arbitration and byte sequencing
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    is_io_d     = is_io_q;
    rw_d        = rw_q;
    nbytes_d    = nbytes_q;
    step_d      = step_q;
    wdata_d     = wdata_q;
    m_valid_d   = m_valid_q;
    m_addr_d    = m_addr_q;
    io_rdata_d  = io_rdata_q;
    fe_rdata_d  = fe_rdata_q;
    io_ready_d  = 1'b0;
    io_error_d  = 1'b0;
    fe_ready_d  = '0;
    fe_error_d  = '0;
    found       = 1'b0;
    last        = 1'b0;
    gsel        = '0;
    cand        = '0;
    fe_addr_sel = '0;

    // A write already on the bus is allowed to finish under ask_inter
    abort = bus.ask_restart || (bus.ask_inter && !((state_q != IDLE) && rw_q));

    // Round-robin: first requesting channel at or after rr_q, wrapping
    for (int unsigned i = 0; i < FETCH_CH; i++) begin
      cand = GW'((32'(rr_q) + i) % FETCH_CH);
      if (!found && bus.fe_valid[cand]) begin
        found = 1'b1;
        gsel  = cand;
      end
    end
    for (int unsigned c = 0; c < FETCH_CH; c++) begin
      if (GW'(c) == gsel) fe_addr_sel = bus.fe_addr[c*ADDR_W +: ADDR_W];
    end

    case (state_q)
      IDLE: begin
        if (!bus.ask_inter && !bus.ask_restart) begin
          if (bus.io_valid) begin
            is_io_d    = 1'b1;
            rw_d       = bus.io_rw;
            nbytes_d   = 4'(1) << bus.io_width;
            // Left-justify the N live bytes so the MSB leaves first
            wdata_d    = bus.io_wdata << (7'd64 - (7'd8 << bus.io_width));
            m_addr_d   = bus.io_addr;
            io_rdata_d = '0;
            step_d     = '0;
            m_valid_d  = 1'b1;
            state_d    = RUN;
          end else if (found) begin
            is_io_d   = 1'b0;
            grant_d   = gsel;
            rr_d      = GW'((32'(gsel) + 32'd1) % FETCH_CH);
            rw_d      = 1'b0;
            nbytes_d  = 4'(INSTR_BYTES);
            wdata_d   = '0;
            m_addr_d  = fe_addr_sel;
            for (int unsigned c = 0; c < FETCH_CH; c++) begin
              if (GW'(c) == gsel) fe_rdata_d[c] = '0;
            end
            step_d    = '0;
            m_valid_d = 1'b1;
            state_d   = RUN;
          end
        end
      end

      RUN: begin
        if (bus.m_ready) begin
          last    = bus.m_error || (step_q == 3'(nbytes_q - 4'd1));
          wdata_d = wdata_q << 8;
          if (!rw_q) begin
            if (is_io_q) io_rdata_d = {io_rdata_q[55:0], bus.m_rdata};
            else begin
              for (int unsigned c = 0; c < FETCH_CH; c++) begin
                if (GW'(c) == grant_q) fe_rdata_d[c] = (fe_rdata_q[c] << 8) | FW'(bus.m_rdata);
              end
            end
          end
          if (bus.m_error) begin
            if (is_io_q) io_rdata_d = '0;
            else begin
              for (int unsigned c = 0; c < FETCH_CH; c++) begin
                if (GW'(c) == grant_q) fe_rdata_d[c] = '0;
              end
            end
          end
          if (last) begin
            state_d   = DONE;
            m_valid_d = 1'b0;
            step_d    = '0;
            if (is_io_q) begin
              io_ready_d = 1'b1;
              io_error_d = bus.m_error;
            end else begin
              for (int unsigned c = 0; c < FETCH_CH; c++) begin
                if (GW'(c) == grant_q) begin
                  fe_ready_d[c] = 1'b1;
                  fe_error_d[c] = bus.m_error;
                end
              end
            end
          end else begin
            step_d   = step_q + 3'd1;
            m_addr_d = m_addr_q + ADDR_W'(1);
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Restart (or interrupt outside a write) drops everything, keeps rr_q
    if (abort) begin
      state_d    = IDLE;
      step_d     = '0;
      m_valid_d  = 1'b0;
      io_ready_d = 1'b0;
      io_error_d = 1'b0;
      fe_ready_d = '0;
      fe_error_d = '0;
    end

    ready_inter_d = !(((state_d == RUN) || (state_d == DONE)) && rw_d);
  end

  assign bus.ready_inter   = ready_inter_q;
  assign bus.ready_restart = 1'b1;
  assign bus.io_rdata      = io_rdata_q;
  assign bus.io_ready      = io_ready_q;
  assign bus.io_error      = io_error_q;
  assign bus.fe_rdata      = fe_rdata_q;
  assign bus.fe_ready      = fe_ready_q;
  assign bus.fe_error      = fe_error_q;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_addr        = m_addr_q;
  assign bus.m_rw          = rw_q;
  assign bus.m_wdata       = wdata_q[63:56];

endmodule

// File: doc/byte_channel_bridge.md
# byte_channel_bridge

Parametrised bridge that serialises one data-IO requester and FETCH_CH instruction-fetch requesters onto a single byte-wide memory channel. It supersedes the single-fetch-port byte bridge: it adds configurable fetch channel count, instruction width and address width, plus round-robin fetch arbitration. It latches request fields at accept and drains in-flight writes before granting an interrupt. It sits between the CPU load/store and fetch units and the byte-serial memory/peripheral bus.

## Interface
- ADDR_W, 40, address width of all ports
- FETCH_CH, 2, number of fetch requester channels (1..8)
- INSTR_BYTES, 4, bytes per fetched instruction (1..8)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ask_inter  in  1  CPU in interrupt-response flow
- ask_restart  in  1  CPU in restart flow
- ready_inter  out  1  bridge ready for interrupt (no write in flight)
- ready_restart  out  1  bridge ready for restart; constant 1
- io_valid  in  1  data task request
- io_addr  in  ADDR_W  data task base address
- io_rw  in  1  0 read, 1 write
- io_width  in  2  0/1/2/3 = 1/2/4/8 bytes
- io_wdata  in  64  write value, right-justified
- io_rdata  out  64  read value, right-justified, zero-extended
- io_ready  out  1  one-cycle task-complete pulse (also on error)
- io_error  out  1  qualifies io_ready: task failed
- fe_valid  in  FETCH_CH  per-channel fetch request
- fe_addr  in  FETCH_CH*ADDR_W  per-channel instruction address, channel i at [i*ADDR_W +: ADDR_W]
- fe_rdata  out  FETCH_CH*8*INSTR_BYTES  per-channel instruction
- fe_ready  out  FETCH_CH  one-hot completion pulse
- fe_error  out  FETCH_CH  qualifies fe_ready
- m_valid  out  1  byte transfer request
- m_addr  out  ADDR_W  byte address
- m_rw  out  1  0 read, 1 write
- m_wdata  out  8  write byte
- m_rdata  in  8  read byte
- m_ready  in  1  byte transfer complete
- m_error  in  1  qualifies m_ready: byte failed

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, all outputs 0 except ready_inter=1 and ready_restart=1; rdata registers 0; round-robin pointer 0.
- IDLE accept, only when ask_inter=0 and ask_restart=0:
  - io_valid has priority over all fetch channels.
  - Otherwise grant the first fe_valid channel at or after the RR pointer, searching upward with wrap-around.
  - The RR pointer becomes grant+1 mod FETCH_CH.
- On accept, latch address, rw, width, wdata and grant into registers. Byte count N = 1<<io_width for io, INSTR_BYTES for fetch; fetch is always a read. Step counter = 0 and the target rdata register is cleared. Go to RUN.
- RUN:
  - m_valid=1, m_addr = base + step (mod 2^ADDR_W), m_rw from latch.
  - Write: m_wdata = byte (N-1-step) of the latched value, so MSB goes to the lowest address (big-endian).
  - On m_ready, a read shifts in: data = (data<<8) | m_rdata.
  - If m_error or step==N-1, go to DONE with error = m_error; otherwise step++.
- DONE, one cycle: the ready (and error if set) of the granted requester pulses, then return to IDLE.
  - rdata holds until the next accept of the same requester.
  - On error, rdata is forced to 0.
- ask_restart=1 (any state): next edge to IDLE. Step and error clear, no ready pulse, RR pointer kept.
- ask_inter=1:
  - If idle, or in RUN/DONE with a read: abort as for restart.
  - If in RUN/DONE with a write: continue to completion and deliver io_ready normally.
  - ready_inter = 0 exactly while a write is in RUN or DONE.
- Simultaneous ask_restart and ask_inter: restart wins (immediate abort, writes included).

## Timing
- Accept edge T, so m_valid is first high in T+1. Each byte holds m_addr/m_wdata stable until m_ready; the next byte is presented the cycle after m_ready.
- Last m_ready at edge E: DONE in the cycle after E, with the ready pulse in that cycle. Back to IDLE after one more edge. Minimum task = N+2 cycles with zero-wait memory.
- A requester must drop valid before the edge following its ready pulse, or it is re-accepted.
- m_ready while m_valid=0 is ignored.

## Test plan
- io write, width=2, addr 0x10, wdata 0xA1B2C3D4 -> m_addr 0x10..0x13 carry A1,B2,C3,D4; one io_ready pulse; io_error=0.
- io read, width=1, memory 0x20=0x5E, 0x21=0x7F -> io_rdata=0x0000_0000_0000_5E7F; io_ready 4 cycles after accept with zero-wait m_ready.
- FETCH_CH=2, both fe_valid held, three fetches -> grants 0,1,0; fe_rdata[ch] = big-endian 4 bytes; fe_ready one-hot per task.
- io_valid and fe_valid[1] asserted in the same cycle -> io served first, then fetch ch1; an io address of 0xFF_FFFF_FFFF with width=1 wraps the second byte to address 0.
- m_error on byte 2 of an 8-byte read -> only 3 byte transfers, io_ready=io_error=1, io_rdata=0.
- ask_inter during byte 1 of a 4-byte write -> ready_inter=0 until after the DONE cycle, all 4 bytes written; ask_restart mid-read -> IDLE next cycle, no ready pulse, next request accepted normally.
